// File: rtl/countdown_timer.sv
// Loadable down-counter with start/abort handshake, programmable prescaler and pause.
// Define COUNTDOWN_AUTO_RELOAD_EN to add the auto_reload input and periodic reload mode.
module countdown_timer #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned PRESCALE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      pause,
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    input  logic                      auto_reload,
`endif
    input  logic [WIDTH-1:0]          load_value,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic [WIDTH-1:0]          count,
    output logic                      busy,
    output logic                      expired,
    output logic                      done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state;
    logic [PRESCALE_WIDTH-1:0] pre_cnt;
    logic [PRESCALE_WIDTH-1:0] pre_lat;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0]          reload_reg;
    logic                      auto_lat;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            busy       <= 1'b0;
            expired    <= 1'b0;
            done       <= 1'b0;
            pre_cnt    <= '0;
            pre_lat    <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_reg <= '0;
            auto_lat   <= 1'b0;
`endif
        end else begin
            expired <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                count   <= '0;
                busy    <= 1'b0;
                done    <= 1'b0;
                pre_cnt <= '0;
            end else begin
                unique case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            count   <= load_value;
                            pre_lat <= prescale;
                            pre_cnt <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            reload_reg <= load_value;
                            auto_lat   <= auto_reload;
`endif
                            if (load_value != '0) begin
                                state <= RUN;
                                busy  <= 1'b1;
                                done  <= 1'b0;
                            end else begin
                                // Zero load expires immediately without passing through RUN.
                                state   <= DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                expired <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (!pause) begin
                            if (pre_cnt == pre_lat) begin
                                pre_cnt <= '0;
                                if (count == WIDTH'(1)) begin
                                    expired <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                                    if (auto_lat) begin
                                        count <= reload_reg;
                                    end else begin
                                        count <= '0;
                                        state <= DONE;
                                        busy  <= 1'b0;
                                        done  <= 1'b1;
                                    end
`else
                                    count <= '0;
                                    state <= DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
`endif
                                end else if (count != '0) begin
                                    count <= count - WIDTH'(1);
                                end
                            end else begin
                                pre_cnt <= pre_cnt + PRESCALE_WIDTH'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer; covers the auto-reload mode
// when COUNTDOWN_AUTO_RELOAD_EN is defined.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       pause;
    logic       auto_reload;
    logic [7:0] load_value;
    logic [3:0] prescale;
    logic [7:0] count;
    logic       busy;
    logic       expired;
    logic       done;

    int tests = 0;
    int fails = 0;

    countdown_timer #(.WIDTH(8), .PRESCALE_WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .pause      (pause),
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        .auto_reload(auto_reload),
`endif
        .load_value (load_value),
        .prescale   (prescale),
        .count      (count),
        .busy       (busy),
        .expired    (expired),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int c, input bit b, input bit x, input bit d);
        check({tag, ".count"},   32'(count),   32'(c));
        check({tag, ".busy"},    32'(busy),    32'(b));
        check({tag, ".expired"}, 32'(expired), 32'(x));
        check({tag, ".done"},    32'(done),    32'(d));
    endtask

    initial begin
        int exp_c;
        reset = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0; auto_reload = 1'b0;
        load_value = '0; prescale = '0;
        #12;
        check_all("reset", 0, 0, 0, 0);
        reset = 1'b0;
        step();

        // One-shot, load 3, prescale 0
        load_value = 8'd3; prescale = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            check_all($sformatf("oneshot_e%0d", e), 4 - e, e < 4, e == 4, e == 4);
            if (e < 4) step();
        end
        step();
        check_all("oneshot_hold", 0, 0, 0, 1);

        // Restart from DONE: load 2, prescale 2, pause sampled on edges 3..6
        load_value = 8'd2; prescale = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        load_value = 8'd99; prescale = 4'd0;
        for (int e = 1; e <= 11; e++) begin
            exp_c = (e <= 7) ? 2 : (e <= 10) ? 1 : 0;
            check_all($sformatf("pause_e%0d", e), exp_c, e < 11, e == 11, e == 11);
            if (e == 2) pause = 1'b1;
            if (e == 6) pause = 1'b0;
            if (e == 8) start = 1'b1;
            if (e == 9) start = 1'b0;
            if (e < 11) step();
        end

        // Zero load from DONE
        load_value = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        check_all("zero_e1", 0, 0, 1, 1);
        step();
        check_all("zero_e2", 0, 0, 0, 1);

        // Abort together with start at count 7
        load_value = 8'd7; prescale = 4'd0; start = 1'b1;
        step();
        check_all("abort_load", 7, 1, 0, 0);
        abort = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        check_all("abort_e1", 0, 0, 0, 0);
        step();
        check_all("abort_idle", 0, 0, 0, 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        auto_reload = 1'b1; load_value = 8'd2; prescale = 4'd0; start = 1'b1;
        step();
        start = 1'b0; auto_reload = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            check_all($sformatf("reload_e%0d", e), (e % 2 == 1) ? 2 : 1, 1, (e == 3) || (e == 5), 0);
            if (e < 6) step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_all("reload_abort", 0, 0, 0, 0);
        step();
`endif

        // Asynchronous reset mid-RUN at count 5
        load_value = 8'd9; prescale = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        check_all("pre_reset", 5, 1, 0, 0);
        #3 reset = 1'b1;
        #1;
        check_all("async_reset", 0, 0, 0, 0);
        step();
        reset = 1'b0;
        step();
        check_all("post_reset", 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
